// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: conditions the three raw push-buttons (synchronise,
// debounce) and turns each debounced press into move-request pulses with
// hold-to-repeat, granting at most one move per cycle (L > R > D).
module tetris_input_ctrl #(
    parameter int CNT_W         = 23,
    parameter int DEBOUNCE      = 250000,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnD,
    output logic       move_left,
    output logic       move_right,
    output logic       move_down,
    output logic [2:0] held
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_e;

    localparam int NCH = 3;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel index 0 = left, 1 = right, 2 = down; this also matches held.
    logic [NCH-1:0]   btnRaw;
    logic [NCH-1:0]   sync1_q;
    logic [NCH-1:0]   sync2_q;
    logic [NCH-1:0]   db_q;
    logic [NCH-1:0]   db_d;
    logic [CNT_W-1:0] dbCnt_q  [NCH];
    logic [CNT_W-1:0] dbCnt_d  [NCH];
    state_e           state_q  [NCH];
    state_e           state_d  [NCH];
    logic [CNT_W-1:0] rptCnt_q [NCH];
    logic [CNT_W-1:0] rptCnt_d [NCH];
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   move_q;
    logic [NCH-1:0]   move_d;
    logic [NCH-1:0]   held_q;

    assign btnRaw = {btnD, btnR, btnL};

    // Two-flop synchroniser bringing the asynchronous buttons into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btnRaw;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: accept a new level only after it has differed for DEBOUNCE cycles.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            db_d[i]    = db_q[i];
            dbCnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dbCnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbCnt_d[i] = dbCnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Repeat FSM: first press requests at once, then after the delay, then every period.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            rptCnt_d[i] = '0;
            req[i]      = 1'b0;
            if (!db_q[i]) begin
                state_d[i] = IDLE;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        req[i]     = 1'b1;
                        state_d[i] = DELAY;
                    end
                    DELAY: begin
                        if (rptCnt_q[i] == RD_LAST) begin
                            req[i]     = 1'b1;
                            state_d[i] = REPEAT;
                        end else begin
                            rptCnt_d[i] = rptCnt_q[i] + CNT_ONE;
                        end
                    end
                    REPEAT: begin
                        if (rptCnt_q[i] == RP_LAST) begin
                            req[i] = 1'b1;
                        end else begin
                            rptCnt_d[i] = rptCnt_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                    end
                endcase
            end
        end
    end

    // Fixed-priority arbiter; losing requests are simply dropped.
    always_comb begin
        move_d = '0;
        if (req[0]) begin
            move_d = 3'b001;
        end else if (req[1]) begin
            move_d = 3'b010;
        end else if (req[2]) begin
            move_d = 3'b100;
        end
    end

    // Per-channel debounce and repeat state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                dbCnt_q[i]  <= '0;
                state_q[i]  <= IDLE;
                rptCnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < NCH; i++) begin
                dbCnt_q[i]  <= dbCnt_d[i];
                state_q[i]  <= state_d[i];
                rptCnt_q[i] <= rptCnt_d[i];
            end
        end
    end

    // Output registers for the granted move pulse and the debounced levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_q <= '0;
            held_q <= '0;
        end else begin
            move_q <= move_d;
            held_q <= db_q;
        end
    end

    assign move_left  = move_q[0];
    assign move_right = move_q[1];
    assign move_down  = move_q[2];
    assign held       = held_q;

endmodule
